// File: rtl/tlp_rx_framer.sv
// Store-and-forward TLP framer: buffers one TLP from the PCIe RX snoop stream,
// then replays it into the TLP FIFO with its byte length and tag on every beat.
module tlp_rx_framer #(
    parameter int DEPTH = 128
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tvalid,
    output logic        s_axis_rx_tready,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [63:0] fifo_tdata,
    output logic [7:0]  fifo_tkeep,
    output logic        fifo_tlast,
    output logic        fifo_tvalid,
    output logic [10:0] fifo_tlp_len,
    output logic [7:0]  fifo_tlp_tag,
    output logic [31:0] tlp_count,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] END_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE     = AW'(1);

    typedef enum logic [1:0] {FILL, DROP, PREP, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr, last_idx;
    logic [10:0]     byte_cnt, byte_add;
    logic [6:0]      fmt_type;
    logic [7:0]      tag_cand, tag_nxt;
    logic [10:0]     len_q;
    logic [7:0]      tag_q;
    logic [63:0]     out_data;
    logic [7:0]      out_keep;
    logic            out_last;
    logic            accept, at_first, at_end, cpl_hdr;

    logic [63:0]     buf_data [DEPTH];
    logic [7:0]      buf_keep [DEPTH];

    assign accept   = s_axis_rx_tvalid && s_axis_rx_tready;
    assign at_first = (wr_ptr == '0);
    assign at_end   = (wr_ptr == END_IDX);
    assign byte_add = (s_axis_rx_tkeep == 8'h0F) ? 11'd4 : 11'd8;
    // Completions carry the tag in DW2, which arrives in the low half of beat 1.
    assign cpl_hdr  = (fmt_type[4:0] == 5'b01010);
    assign tag_nxt  = (wr_ptr == ONE && cpl_hdr) ? s_axis_rx_tdata[15:8] : tag_cand;

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) state <= FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        s_axis_rx_tready = 1'b0;
        fifo_wr_en       = 1'b0;
        case (state)
            FILL: begin
                s_axis_rx_tready = !pcie_rst;
                if (accept) begin
                    if (s_axis_rx_tlast) state_nxt = at_first ? FILL : PREP;
                    else if (at_end)     state_nxt = DROP;
                end
            end
            DROP: begin
                s_axis_rx_tready = !pcie_rst;
                if (accept && s_axis_rx_tlast) state_nxt = FILL;
            end
            PREP: state_nxt = DRAIN;
            DRAIN: begin
                fifo_wr_en = !fifo_full;
                if (fifo_wr_en && out_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Buffer storage is not reset; its contents are only read after a full fill.
    always_ff @(posedge pcie_clk) begin
        if (state == FILL && accept) begin
            buf_data[wr_ptr] <= s_axis_rx_tdata;
            buf_keep[wr_ptr] <= s_axis_rx_tkeep;
        end
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_idx   <= '0;
            byte_cnt   <= '0;
            fmt_type   <= '0;
            tag_cand   <= '0;
            len_q      <= '0;
            tag_q      <= '0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            tlp_count  <= '0;
            drop_count <= '0;
        end else begin
            case (state)
                FILL: if (accept) begin
                    if (at_first) begin
                        fmt_type <= s_axis_rx_tdata[30:24];
                        tag_cand <= s_axis_rx_tdata[47:40];
                    end else if (wr_ptr == ONE && cpl_hdr) begin
                        tag_cand <= s_axis_rx_tdata[15:8];
                    end
                    if (s_axis_rx_tlast) begin
                        wr_ptr   <= '0;
                        byte_cnt <= '0;
                        if (at_first) begin
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        end else begin
                            len_q    <= byte_cnt + byte_add;
                            tag_q    <= tag_nxt;
                            last_idx <= wr_ptr;
                        end
                    end else if (at_end) begin
                        wr_ptr   <= '0;
                        byte_cnt <= '0;
                        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                    end else begin
                        wr_ptr   <= wr_ptr + ONE;
                        byte_cnt <= byte_cnt + byte_add;
                    end
                end
                PREP: begin
                    out_data <= buf_data[0];
                    out_keep <= buf_keep[0];
                    out_last <= (last_idx == '0);
                    rd_ptr   <= ONE;
                end
                DRAIN: if (fifo_wr_en) begin
                    if (out_last) begin
                        tlp_count <= tlp_count + 32'd1;
                        rd_ptr    <= '0;
                    end else begin
                        out_data <= buf_data[rd_ptr];
                        out_keep <= buf_keep[rd_ptr];
                        out_last <= (rd_ptr == last_idx);
                        rd_ptr   <= rd_ptr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_tdata   = out_data;
    assign fifo_tkeep   = out_keep;
    assign fifo_tlast   = out_last;
    assign fifo_tvalid  = fifo_wr_en;
    assign fifo_tlp_len = len_q;
    assign fifo_tlp_tag = tag_q;

endmodule

// File: tb/tb_tlp_rx_framer.sv
// Directed bench for tlp_rx_framer: expected FIFO beats are queued at stimulus
// time and checked by an independent monitor whenever fifo_wr_en is seen.
module tb_tlp_rx_framer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0, tvalid = 1'b0, tready;
    logic        fifo_wr_en, fifo_full = 1'b0;
    logic [63:0] fifo_tdata;
    logic [7:0]  fifo_tkeep;
    logic        fifo_tlast, fifo_tvalid;
    logic [10:0] fifo_tlp_len;
    logic [7:0]  fifo_tlp_tag;
    logic [31:0] tlp_count;
    logic [15:0] drop_count;

    tlp_rx_framer #(.DEPTH(DEPTH)) dut (
        .pcie_clk(clk), .pcie_rst(rst),
        .s_axis_rx_tdata(tdata), .s_axis_rx_tkeep(tkeep), .s_axis_rx_tlast(tlast),
        .s_axis_rx_tvalid(tvalid), .s_axis_rx_tready(tready),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .fifo_tdata(fifo_tdata), .fifo_tkeep(fifo_tkeep), .fifo_tlast(fifo_tlast),
        .fifo_tvalid(fifo_tvalid), .fifo_tlp_len(fifo_tlp_len), .fifo_tlp_tag(fifo_tlp_tag),
        .tlp_count(tlp_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [10:0] len;
        logic [7:0]  tag;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0, errors = 0;
    logic [63:0] tlp_data [16];
    logic [7:0]  tlp_keep [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the next queued beat.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (fifo_wr_en === 1'b1) begin
            chk("wr_while_full", fifo_full, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", fifo_tdata, 64'hx);
            end else begin
                e = exp_q.pop_front();
                chk("fifo_tdata",  fifo_tdata,   e.data);
                chk("fifo_tkeep",  fifo_tkeep,   e.keep);
                chk("fifo_tlast",  fifo_tlast,   e.last);
                chk("fifo_len",    fifo_tlp_len, e.len);
                chk("fifo_tag",    fifo_tlp_tag, e.tag);
                chk("fifo_tvalid", fifo_tvalid,  1);
            end
        end
    end

    // Drive n beats from tlp_data/tlp_keep; the first nexp are expected at the FIFO.
    task automatic send(input int n, input int nexp, input logic [10:0] len, input logic [7:0] tag);
        beat_t b;
        for (int i = 0; i < nexp; i++) begin
            b.data = tlp_data[i]; b.keep = tlp_keep[i]; b.last = (i == n - 1);
            b.len = len; b.tag = tag;
            exp_q.push_back(b);
        end
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            tvalid = 1'b1; tdata = tlp_data[i]; tkeep = tlp_keep[i]; tlast = (i == n - 1);
            @(negedge clk);
            while (tready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
            if (guard >= 100) begin chk("tready_timeout", guard, 0); break; end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin @(posedge clk); g++; end
        if (g >= 200) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic fill_ff(input int n, input logic [63:0] h0, input logic [31:0] seed);
        tlp_data[0] = h0; tlp_keep[0] = 8'hFF;
        for (int i = 1; i < n; i++) begin
            tlp_data[i] = {seed + 32'(2 * i + 1), seed + 32'(2 * i)};
            tlp_keep[i] = 8'hFF;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_tvalid", fifo_tvalid, 0);
        chk("rst_tdata", fifo_tdata, 0);
        chk("rst_tlp_count", tlp_count, 0);
        chk("rst_drop_count", drop_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tready", tready, 1);
        @(posedge clk); #1;

        // 3DW MWr, 1 DW payload, tag in DW1
        tlp_data[0] = {32'h00015A0F, 32'h40000001}; tlp_keep[0] = 8'hFF;
        tlp_data[1] = {32'hDEADBEEF, 32'h12345678}; tlp_keep[1] = 8'hFF;
        send(2, 2, 11'd16, 8'h5A);
        @(negedge clk);
        chk("prep_no_wr", fifo_wr_en, 0);
        chk("prep_tready", tready, 0);
        @(negedge clk);
        chk("first_wr_latency", fifo_wr_en, 1);
        wait_drain();
        chk("mwr_tlp_count", tlp_count, 1);
        chk("mwr_tready_after", tready, 1);

        // CplD, 3DW header + 4 DW data, tag in DW2 overrides DW1 byte
        tlp_data[0] = {32'h01007710, 32'h4A000004}; tlp_keep[0] = 8'hFF;
        tlp_data[1] = {32'hCAFE0001, 32'h00002100}; tlp_keep[1] = 8'hFF;
        tlp_data[2] = {32'hCAFE0003, 32'hCAFE0002}; tlp_keep[2] = 8'hFF;
        tlp_data[3] = {32'h00000000, 32'hCAFE0004}; tlp_keep[3] = 8'h0F;
        send(4, 4, 11'd28, 8'h21);
        wait_drain();
        chk("cpld_tlp_count", tlp_count, 2);

        // Back-pressure: fifo_full for 5 cycles after the first write
        fill_ff(4, {32'h0000A50F, 32'h40000003}, 32'h11110000);
        send(4, 4, 11'd32, 8'hA5);
        @(posedge clk); @(posedge clk); #1 fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_no_wr", fifo_wr_en, 0);
            chk("stall_tready", tready, 0);
            chk("stall_hold", fifo_tdata, tlp_data[1]);
            @(posedge clk);
        end
        #1 fifo_full = 1'b0;
        wait_drain();
        chk("bp_tlp_count", tlp_count, 3);

        // Oversize: DEPTH+3 beats dropped, then a normal TLP
        fill_ff(DEPTH + 3, {32'h0000770F, 32'h40000004}, 32'h22220000);
        send(DEPTH + 3, 0, 11'd0, 8'h00);
        repeat (4) @(posedge clk); #1;
        chk("oversize_drop", drop_count, 1);
        chk("oversize_tlp_count", tlp_count, 3);
        fill_ff(2, {32'h00003C0F, 32'h40000005}, 32'h33330000);
        send(2, 2, 11'd16, 8'h3C);
        wait_drain();
        chk("after_oversize_count", tlp_count, 4);

        // Single-beat TLP is malformed
        tlp_data[0] = {32'h0000990F, 32'h00000006}; tlp_keep[0] = 8'hFF;
        send(1, 0, 11'd0, 8'h00);
        repeat (3) @(posedge clk); #1;
        chk("single_drop", drop_count, 2);
        chk("single_tlp_count", tlp_count, 4);
        chk("single_tready", tready, 1);

        // Reset during DRAIN after the first of four beats
        fill_ff(4, {32'h0000E10F, 32'h40000007}, 32'h44440000);
        send(4, 1, 11'd32, 8'hE1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tready", tready, 0);
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        chk("mid_rst_tvalid", fifo_tvalid, 0);
        chk("mid_rst_tdata", fifo_tdata, 0);
        chk("mid_rst_tkeep", fifo_tkeep, 0);
        chk("mid_rst_tlast", fifo_tlast, 0);
        chk("mid_rst_len", fifo_tlp_len, 0);
        chk("mid_rst_tag", fifo_tlp_tag, 0);
        chk("mid_rst_tlp_count", tlp_count, 0);
        chk("mid_rst_drop_count", drop_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_release_tready", tready, 1);
        @(posedge clk); #1;
        fill_ff(2, {32'h0000660F, 32'h40000008}, 32'h55550000);
        send(2, 2, 11'd16, 8'h66);
        wait_drain();
        chk("post_rst_tlp_count", tlp_count, 1);
        chk("post_rst_drop_count", drop_count, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
